// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, delay-line record and total helper
package vga_pkg;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // 640x480@60, negative sync polarity
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_POL      = 1'b0;

  // 800x600@60, positive sync polarity
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_POL      = 1'b1;

  // 1024x768@60, negative sync polarity
  localparam int XGA1024_H_ACTIVE = 1024;
  localparam int XGA1024_H_FP     = 24;
  localparam int XGA1024_H_SYNC   = 136;
  localparam int XGA1024_H_BP     = 160;
  localparam int XGA1024_V_ACTIVE = 768;
  localparam int XGA1024_V_FP     = 3;
  localparam int XGA1024_V_SYNC   = 6;
  localparam int XGA1024_V_BP     = 29;
  localparam bit XGA1024_POL      = 1'b0;

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - one raster axis: wrap counter plus active/sync decode of the next count
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap,
  output logic         o_active_d,
  output logic         o_sync_d
);

  localparam int TOTAL = calc_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Decodes look at the next count so the caller can register them alongside it.
  assign o_cnt      = cnt_q;
  assign o_wrap     = (cnt_q == LAST);
  assign o_active_d = (cnt_d < ACT_END);
  assign o_sync_d   = (cnt_d >= SYNC_LO && cnt_d < SYNC_HI) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel-strobed VGA raster timing with aligned, delayable sync/DE
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE_DLY = 2,
  parameter int CNT_W    = 12,
  parameter int FRAME_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_en,
  output logic [CNT_W-1:0]   o_x,
  output logic [CNT_W-1:0]   o_y,
  output logic               o_de,
  output logic               o_sol,
  output logic               o_sof,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de_dly,
  output logic [FRAME_W-1:0] o_frame
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam sync_t IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0};

  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_pipe_check
    $error("vga_timing_gen: PIPE_DLY must be 0..15");
  end

  logic h_wrap, v_wrap, h_act_d, v_act_d, h_sync_d, v_sync_d;
  logic frame_end;

  vga_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(CNT_W)
  ) u_h_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_pix_en),
    .o_cnt(o_x), .o_wrap(h_wrap), .o_active_d(h_act_d), .o_sync_d(h_sync_d)
  );

  vga_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(CNT_W)
  ) u_v_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_pix_en & h_wrap),
    .o_cnt(o_y), .o_wrap(v_wrap), .o_active_d(v_act_d), .o_sync_d(v_sync_d)
  );

  assign frame_end = i_pix_en & h_wrap & v_wrap;

  logic               sol_q, sof_q;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (frame_end) frame_d = frame_q + FRAME_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sol_q   <= 1'b0;
      sof_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      sol_q   <= i_pix_en & h_wrap;
      sof_q   <= frame_end;
      frame_q <= frame_d;
    end
  end

  // Stage 0 holds the undelayed terms for the current x/y; stage N lags by N pixel strobes.
  sync_t dl_q [0:PIPE_DLY];
  sync_t stage_d;

  assign stage_d = '{hs: h_sync_d, vs: v_sync_d, de: h_act_d & v_act_d};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= PIPE_DLY; i++) dl_q[i] <= IDLE;
    end else if (i_pix_en) begin
      dl_q[0] <= stage_d;
      for (int i = 1; i <= PIPE_DLY; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign o_de     = dl_q[0].de;
  assign o_hsync  = dl_q[PIPE_DLY].hs;
  assign o_vsync  = dl_q[PIPE_DLY].vs;
  assign o_de_dly = dl_q[PIPE_DLY].de;
  assign o_sol    = sol_q;
  assign o_sof    = sof_q;
  assign o_frame  = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of vga_timing_gen on a tiny 8x6 raster
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_de, a_sol, a_sof, a_hs, a_vs, a_dd;
  logic b_de, b_sol, b_sof, b_hs, b_vs, b_dd;
  logic c_de, c_sol, c_sof, c_hs, c_vs, c_dd;
  logic [7:0] a_frame, b_frame;
  logic [1:0] c_frame;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(0), .CNT_W(12), .FRAME_W(8)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(a_x), .o_y(a_y), .o_de(a_de),
    .o_sol(a_sol), .o_sof(a_sof), .o_hsync(a_hs), .o_vsync(a_vs), .o_de_dly(a_dd), .o_frame(a_frame));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(3), .CNT_W(12), .FRAME_W(8)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(b_x), .o_y(b_y), .o_de(b_de),
    .o_sol(b_sol), .o_sof(b_sof), .o_hsync(b_hs), .o_vsync(b_vs), .o_de_dly(b_dd), .o_frame(b_frame));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(0), .CNT_W(12), .FRAME_W(2)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(c_x), .o_y(c_y), .o_de(c_de),
    .o_sol(c_sol), .o_sof(c_sof), .o_hsync(c_hs), .o_vsync(c_vs), .o_de_dly(c_dd), .o_frame(c_frame));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pix_en = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (a_x !== 12'd0 || a_y !== 12'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d exp 0,0", a_x, a_y); end
    checks++; if (a_frame !== 8'd0) begin errors++; $display("FAIL reset_frame got %0d exp 0", a_frame); end
    checks++; if ({a_de, a_sol, a_sof, a_dd} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {a_de, a_sol, a_sof, a_dd}); end
    checks++; if ({a_hs, a_vs} !== 2'b11) begin errors++; $display("FAIL reset_sync_low_pol got %b exp 11", {a_hs, a_vs}); end
    checks++; if ({b_hs, b_vs, b_dd} !== 3'b110) begin errors++; $display("FAIL reset_dly_line got %b exp 110", {b_hs, b_vs, b_dd}); end
    checks++; if ({c_hs, c_vs} !== 2'b00) begin errors++; $display("FAIL reset_sync_high_pol got %b exp 00", {c_hs, c_vs}); end
    rst_n = 1'b1;
  endtask

  task automatic test_raster();
    int ex, ey, de_cnt;
    logic exp_de;
    apply_reset();
    rst_n = 1'b1;
    de_cnt = 0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      ex = k % 8;
      ey = (k / 8) % 6;
      exp_de = (ex < 4) && (ey < 3);
      if (a_de === 1'b1) de_cnt++;
      checks++; if (a_x !== 12'(ex) || a_y !== 12'(ey)) begin errors++; $display("FAIL raster_xy k=%0d got %0d,%0d exp %0d,%0d", k, a_x, a_y, ex, ey); end
      checks++; if (a_de !== exp_de) begin errors++; $display("FAIL raster_de k=%0d got %b exp %b", k, a_de, exp_de); end
      checks++; if (a_sol !== (ex == 0)) begin errors++; $display("FAIL raster_sol k=%0d got %b exp %b", k, a_sol, (ex == 0)); end
      checks++; if (a_sof !== (k == 48)) begin errors++; $display("FAIL raster_sof k=%0d got %b exp %b", k, a_sof, (k == 48)); end
    end
    checks++; if (de_cnt != 12) begin errors++; $display("FAIL raster_de_count got %0d exp 12", de_cnt); end
    checks++; if (a_frame !== 8'd1) begin errors++; $display("FAIL raster_frame got %0d exp 1", a_frame); end
  endtask

  task automatic test_sync();
    int ex, ey;
    logic exp_hs, exp_vs;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      ex = k % 8;
      ey = (k / 8) % 6;
      exp_hs = !(ex == 5 || ex == 6);
      exp_vs = !(ey == 4);
      checks++; if (a_hs !== exp_hs) begin errors++; $display("FAIL sync_h k=%0d got %b exp %b", k, a_hs, exp_hs); end
      checks++; if (a_vs !== exp_vs) begin errors++; $display("FAIL sync_v k=%0d got %b exp %b", k, a_vs, exp_vs); end
    end
  endtask

  task automatic test_pix_en_toggle();
    int mx, my, mf;
    logic en, exp_sol, exp_sof, exp_de, exp_hs;
    apply_reset();
    rst_n = 1'b1;
    mx = 0; my = 0; mf = 0;
    for (int k = 1; k <= 96; k++) begin
      en = (k % 2) == 1;
      pix_en = en;
      tick();
      if (en) begin
        mx = (mx + 1) % 8;
        if (mx == 0) my = (my + 1) % 6;
        if (mx == 0 && my == 0) mf++;
      end
      exp_sol = en && (mx == 0);
      exp_sof = en && (mx == 0) && (my == 0);
      exp_de = (mf > 0 || mx != 0 || my != 0) && (mx < 4) && (my < 3);
      exp_hs = !(mx == 5 || mx == 6);
      checks++; if (a_x !== 12'(mx) || a_y !== 12'(my)) begin errors++; $display("FAIL toggle_xy k=%0d got %0d,%0d exp %0d,%0d", k, a_x, a_y, mx, my); end
      checks++; if (a_de !== exp_de || a_hs !== exp_hs) begin errors++; $display("FAIL toggle_de_hs k=%0d got %b%b exp %b%b", k, a_de, a_hs, exp_de, exp_hs); end
      checks++; if (a_sol !== exp_sol || a_sof !== exp_sof) begin errors++; $display("FAIL toggle_sol_sof k=%0d got %b%b exp %b%b", k, a_sol, a_sof, exp_sol, exp_sof); end
      checks++; if (a_frame !== 8'(mf)) begin errors++; $display("FAIL toggle_frame k=%0d got %0d exp %0d", k, a_frame, mf); end
    end
    pix_en = 1'b1;
    checks++; if (a_frame !== 8'd1) begin errors++; $display("FAIL toggle_frame_96 got %0d exp 1", a_frame); end
  endtask

  task automatic test_pipe_delay();
    int j;
    logic exp_hs, exp_vs, exp_dd, exp_de;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      j = k - 3;
      exp_hs = (j < 1) ? 1'b1 : !((j % 8) == 5 || (j % 8) == 6);
      exp_vs = (j < 1) ? 1'b1 : !(((j / 8) % 6) == 4);
      exp_dd = (j < 1) ? 1'b0 : (((j % 8) < 4) && (((j / 8) % 6) < 3));
      exp_de = ((k % 8) < 4) && (((k / 8) % 6) < 3);
      checks++; if (b_hs !== exp_hs || b_vs !== exp_vs) begin errors++; $display("FAIL dly_sync k=%0d got %b%b exp %b%b", k, b_hs, b_vs, exp_hs, exp_vs); end
      checks++; if (b_dd !== exp_dd) begin errors++; $display("FAIL dly_de k=%0d got %b exp %b", k, b_dd, exp_dd); end
      checks++; if (b_x !== 12'(k % 8) || b_de !== exp_de) begin errors++; $display("FAIL dly_undelayed k=%0d got x=%0d de=%b exp x=%0d de=%b", k, b_x, b_de, k % 8, exp_de); end
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 38; k++) tick();
    checks++; if (a_x !== 12'd6 || a_y !== 12'd4 || a_hs !== 1'b0 || a_vs !== 1'b0) begin errors++; $display("FAIL midrst_pre got x=%0d y=%0d hs=%b vs=%b exp 6,4,0,0", a_x, a_y, a_hs, a_vs); end
    rst_n = 1'b0;
    tick();
    checks++; if (a_x !== 12'd0 || a_y !== 12'd0) begin errors++; $display("FAIL midrst_xy got %0d,%0d exp 0,0", a_x, a_y); end
    checks++; if ({a_hs, a_vs} !== 2'b11) begin errors++; $display("FAIL midrst_sync got %b exp 11", {a_hs, a_vs}); end
    checks++; if ({a_de, a_sof, a_sol} !== 3'b000 || a_frame !== 8'd0) begin errors++; $display("FAIL midrst_strobes got de/sof/sol=%b frame=%0d exp 000,0", {a_de, a_sof, a_sol}, a_frame); end
    rst_n = 1'b1;
    tick();
    checks++; if (a_x !== 12'd1 || a_y !== 12'd0 || a_sof !== 1'b0) begin errors++; $display("FAIL midrst_first got x=%0d y=%0d sof=%b exp 1,0,0", a_x, a_y, a_sof); end
  endtask

  task automatic test_polarity_frame_wrap();
    int ex, ey;
    logic exp_hs, exp_vs;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 192; k++) begin
      tick();
      ex = k % 8;
      ey = (k / 8) % 6;
      exp_hs = (ex == 5 || ex == 6);
      exp_vs = (ey == 4);
      checks++; if (c_hs !== exp_hs || c_vs !== exp_vs) begin errors++; $display("FAIL pol_sync k=%0d got %b%b exp %b%b", k, c_hs, c_vs, exp_hs, exp_vs); end
      checks++; if (c_frame !== 2'((k / 48) % 4)) begin errors++; $display("FAIL pol_frame k=%0d got %0d exp %0d", k, c_frame, (k / 48) % 4); end
    end
    checks++; if (c_frame !== 2'd0 || c_sof !== 1'b1) begin errors++; $display("FAIL pol_frame_wrap got frame=%0d sof=%b exp 0,1", c_frame, c_sof); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raster();
    test_sync();
    test_pix_en_toggle();
    test_pipe_delay();
    test_reset_mid_frame();
    test_polarity_frame_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised, single-clock VGA raster timing generator. It supersedes the free-running hsync/vsync counter pair.
- Produces pixel coordinates, a data-enable signal, polarity-configurable sync pulses, and start-of-line and start-of-frame strobes.
- Horizontal and vertical counters advance on a pixel-enable strobe, so any system clock can drive any pixel rate.
- Sync and data-enable outputs have a parameterised delay that aligns them with a downstream pixel-colour pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, asserted level of hsync (0 = active-low)
V_POL, 0, asserted level of vsync
PIPE_DLY, 2, pixel-strobe delay applied to o_hsync/o_vsync/o_de_dly (0..15)
CNT_W, 12, width of coordinate outputs
FRAME_W, 8, width of frame counter

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  synchronous active-low reset
i_pix_en  in  1  pixel strobe; timing advances only when 1
o_x  out  CNT_W  horizontal position 0..H_TOTAL-1
o_y  out  CNT_W  vertical position 0..V_TOTAL-1
o_de  out  1  active video, aligned with o_x/o_y
o_sol  out  1  one-clock pulse when o_x becomes 0
o_sof  out  1  one-clock pulse when o_x and o_y both become 0
o_hsync  out  1  horizontal sync, delayed PIPE_DLY strobes
o_vsync  out  1  vertical sync, delayed PIPE_DLY strobes
o_de_dly  out  1  o_de delayed PIPE_DLY strobes
o_frame  out  FRAME_W  completed-frame count, wraps

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed likewise. Elaboration fails if H_TOTAL or V_TOTAL ≥ 2^CNT_W.
- Reset: i_rst_n sampled low at a clock edge forces the following:
  - o_x, o_y, o_frame = 0.
  - o_de, o_sol, o_sof, o_de_dly = 0.
  - o_hsync = ~H_POL and o_vsync = ~V_POL (inactive).
  - All delay-line stages cleared to the inactive level.
- Reset has priority over i_pix_en. Reset mid-frame restarts at (0,0) with no partial pulses.
- The first pixel strobe after reset release moves to (1,0). No o_sof is emitted for the reset frame.
- Counters, on a clock with i_pix_en=1:
  - o_x <= (o_x == H_TOTAL-1) ? 0 : o_x+1.
  - On horizontal wrap: o_y <= (o_y == V_TOTAL-1) ? 0 : o_y+1.
  - On vertical wrap: o_frame <= o_frame+1, modulo 2^FRAME_W.
  - With i_pix_en=0, all counters, the delay line and the sync levels hold.
- o_de is registered and equals (x < H_ACTIVE) && (y < V_ACTIVE), evaluated on the new x/y. It always describes the current o_x/o_y.
- o_sol / o_sof are high for exactly one i_clk cycle: the cycle in which o_x (and o_y) have just become 0 by wrap. They are low whenever i_pix_en was 0 on the previous edge.
- Undelayed sync terms:
  - hs_raw is asserted (= H_POL) when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, otherwise ~H_POL.
  - vs_raw is asserted (= V_POL) when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC.
  - vs_raw changes only together with y, so vsync edges coincide with x=0.
- Delay line:
  - hs_raw, vs_raw and o_de shift through PIPE_DLY stages, advancing only on i_pix_en.
  - PIPE_DLY=0 makes o_hsync/o_vsync/o_de_dly equal the raw terms in the same cycle as o_x.
- Glitch-free outputs: every output is driven directly from a flop. No combinational paths from i_pix_en to outputs.
- Continuous i_pix_en=1 gives a frame period of exactly H_TOTAL*V_TOTAL clocks.

Decomposition:
- Package vga_pkg holds:
  - Standard timing constants for 640x480@60 (the defaults above), 800x600@60 (800/40/128/88, 600/1/4/23, positive polarity) and 1024x768@60.
  - A localparam function computing totals.
- Sub-module vga_axis_cnt is one generic wrap counter with an active/sync window decode. It is instantiated twice: horizontal (enable = i_pix_en) and vertical (enable = i_pix_en && h_wrap).
- The delay line is a generic in-module shift register.

Test Plan:
Tiny timing H=4/1/2/1 (H_TOTAL 8), V=3/1/1/1 (V_TOTAL 6), PIPE_DLY=0, i_pix_en=1, polarities 0:
1. Reset release, 48 clocks:
   - o_x sequence 0..7 repeating; o_y steps at each x wrap and wraps 5->0.
   - o_sof once at clock 48; o_frame=1.
   - o_de high for exactly 12 of 48 clocks.
2. Same run, check sync:
   - o_hsync low exactly at x=5,6 on every line.
   - o_vsync low exactly for y=4, spanning 8 clocks starting at x=0.
3. i_pix_en toggling 1,0,1,0:
   - Every output holds on i_pix_en=0 cycles.
   - Frame takes 96 clocks; o_sol width stays 1 clock.
4. PIPE_DLY=3: o_hsync/o_de_dly equal the PIPE_DLY=0 waveforms shifted by exactly 3 pixel strobes. o_x/o_de are unchanged.
5. Assert i_rst_n=0 at (x=6,y=4) for one clock:
   - Next cycle x=0,y=0, o_hsync=o_vsync=1, o_de=0, o_frame=0.
   - No o_sof on that cycle.
6. H_POL=V_POL=1, FRAME_W=2: sync pulses are inverted (high-active), and o_frame wraps 3->0 after the 4th frame.
